// File: rtl/data_read_pkg.sv
// Shared definitions for the capture controller, the ring buffer and the bus-side reader.
package data_read_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CH     = 4;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StWait,
    StPost,
    StDone
  } state_e;

  function automatic logic is_writing(state_e s);
    return (s == StPre) || (s == StWait) || (s == StPost);
  endfunction

endpackage

// File: rtl/data_read_trig_detect.sv
// Edge/force trigger detector on the registered sample stream; event is valid for one cycle.
module data_read_trig_detect
  import data_read_pkg::*;
#(
  parameter int unsigned CH = data_read_pkg::CH
) (
  input  logic          wr_clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CH-1:0] s1,
  input  logic [CH-1:0] trig_en,
  input  logic          trig_pol,
  input  logic          force_trig,
  output logic          trig
);

  logic [CH-1:0] s1_prev;
  logic [CH-1:0] edges;

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      s1_prev <= '0;
    end else if (en) begin
      s1_prev <= s1;
    end
  end

  assign edges = trig_pol ? (s1 & ~s1_prev) : (~s1 & s1_prev);
  assign trig  = en & ((|(trig_en & edges)) | force_trig);

endmodule

// File: rtl/data_read_capture.sv
// Capture controller filling the circular sample buffer around a trigger.
// Optional decimation strobe: define DATA_READ_CAPTURE_DECIM_EN to add the decim port.
module data_read_capture
  import data_read_pkg::*;
#(
  parameter int unsigned ADDR_W = data_read_pkg::ADDR_W,
  parameter int unsigned CH     = data_read_pkg::CH
) (
  input  logic              wr_clk,
  input  logic              rst,
  input  logic [CH-1:0]     lvds_data,
  input  logic              arm,
  input  logic              abort,
  input  logic              force_trig,
  input  logic [CH-1:0]     trig_en,
  input  logic              trig_pol,
  input  logic [ADDR_W-1:0] pre_len,
`ifdef DATA_READ_CAPTURE_DECIM_EN
  input  logic [7:0]        decim,
`endif
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CH-1:0]     wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pre_q, pre_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [CH-1:0]     s1;
  logic              strobe;
  logic              trig;
  logic              done_q;

`ifdef DATA_READ_CAPTURE_DECIM_EN
  logic [7:0] div_q;

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (div_q >= decim) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

  assign strobe = (div_q >= decim);
`else
  assign strobe = 1'b1;
`endif

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else if (strobe) begin
      s1 <= lvds_data;
    end
  end

  data_read_trig_detect #(
    .CH(CH)
  ) u_trig_detect (
    .wr_clk    (wr_clk),
    .rst       (rst),
    .en        (strobe),
    .s1        (s1),
    .trig_en   (trig_en),
    .trig_pol  (trig_pol),
    .force_trig(force_trig),
    .trig      (trig)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    pre_d       = pre_q;
    trig_addr_d = trig_addr_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (arm) begin
          addr_d  = '0;
          cnt_d   = '0;
          pre_d   = pre_len;
          state_d = (pre_len == '0) ? StWait : StPre;
        end
      end
      StPre: begin
        if (strobe) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q + ADDR_W'(1);
          if (cnt_q == pre_q - ADDR_W'(1)) begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (strobe) begin
          addr_d = addr_q + ADDR_W'(1);
          if (trig) begin
            trig_addr_d = addr_q;
            // cnt now counts post-trigger writes still owed: DEPTH - pre - 1 == ~pre (mod DEPTH)
            cnt_d       = ~pre_q;
            state_d     = (pre_q == '1) ? StDone : StPost;
          end
        end
      end
      StPost: begin
        if (strobe) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - ADDR_W'(1);
          if (cnt_q == ADDR_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      cnt_q       <= '0;
      pre_q       <= '0;
      trig_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      trig_addr_q <= trig_addr_d;
    end
  end

  // Write stage; done is delayed so it rises the cycle after the last visible write.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done_q  <= 1'b0;
    end else begin
      wr_en   <= is_writing(state_q) && strobe && !abort;
      wr_addr <= addr_q;
      wr_data <= s1;
      done_q  <= (state_q == StDone);
    end
  end

  assign busy      = is_writing(state_q);
  assign done      = done_q && (state_q == StDone);
  assign trig_addr = trig_addr_q;

endmodule
